// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of transparent-high latches: presents data, pulses one
// entry enable, then holds the data, with programmable setup/pulse/hold cycle counts.
module latch_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic [WIDTH-1:0] LAT_D,
    output logic [DEPTH-1:0] LAT_EN,
    output logic             BUSY,
    output logic             ADDR_ERR,
    output logic [7:0]       WR_CNT
);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [DEPTH-1:0]   en_q, en_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic               accept;
    logic               legal;

    assign accept = WR_VALID && ready_q;
    assign legal  = {1'b0, WR_ADDR} < (AW+1)'(DEPTH);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    addr_d  = WR_ADDR;
                    data_d  = WR_DATA;
                    cnt_d   = 4'(SETUP_CYC - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(PULSE_CYC - 1);
                    state_d = OPEN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            OPEN: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'(HOLD_CYC - 1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    wcnt_d  = wcnt_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        en_d    = '0;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        err_d   = (state_q == IDLE) && accept && !legal;
        if (state_d == OPEN) begin
            en_d = DEPTH'(1) << addr_d;
        end
    end

    assign LAT_D    = data_q;
    assign LAT_EN   = en_q;
    assign WR_READY = ready_q;
    assign BUSY     = busy_q;
    assign ADDR_ERR = err_q;
    assign WR_CNT   = wcnt_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: three instances (default, stretched timing, DEPTH=6)
// checked against cycle-offset timing rules and a behavioural latch-array model.
module tb_latch_bank_writer;

    logic       CLK;
    logic       RSTB;
    logic       v_a   [3];
    logic [2:0] a_a   [3];
    logic [7:0] d_a   [3];
    logic       rdy_a [3];
    logic [7:0] d_o   [3];
    logic       busy_a[3];
    logic       err_a [3];
    logic [7:0] cnt_a [3];
    logic [7:0] en0, en1;
    logic [5:0] en2;

    int tests = 0;
    int fails = 0;

    int S_P [3] = '{1, 2, 1};
    int P_P [3] = '{1, 3, 1};
    int H_P [3] = '{1, 2, 1};
    int D_P [3] = '{8, 8, 6};

    logic [7:0] tr_en  [32];
    logic [7:0] tr_d   [32];
    logic [7:0] tr_cnt [32];
    logic       tr_rdy [32];
    logic       tr_busy[32];
    logic       tr_err [32];

    logic [7:0] mem [3][8];

    latch_bank_writer #(.WIDTH(8), .DEPTH(8), .AW(3), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u0 (
        .CLK(CLK), .RSTB(RSTB), .WR_VALID(v_a[0]), .WR_READY(rdy_a[0]), .WR_ADDR(a_a[0]),
        .WR_DATA(d_a[0]), .LAT_D(d_o[0]), .LAT_EN(en0), .BUSY(busy_a[0]), .ADDR_ERR(err_a[0]),
        .WR_CNT(cnt_a[0]));

    latch_bank_writer #(.WIDTH(8), .DEPTH(8), .AW(3), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u1 (
        .CLK(CLK), .RSTB(RSTB), .WR_VALID(v_a[1]), .WR_READY(rdy_a[1]), .WR_ADDR(a_a[1]),
        .WR_DATA(d_a[1]), .LAT_D(d_o[1]), .LAT_EN(en1), .BUSY(busy_a[1]), .ADDR_ERR(err_a[1]),
        .WR_CNT(cnt_a[1]));

    latch_bank_writer #(.WIDTH(8), .DEPTH(6), .AW(3), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u2 (
        .CLK(CLK), .RSTB(RSTB), .WR_VALID(v_a[2]), .WR_READY(rdy_a[2]), .WR_ADDR(a_a[2]),
        .WR_DATA(d_a[2]), .LAT_D(d_o[2]), .LAT_EN(en2), .BUSY(busy_a[2]), .ADDR_ERR(err_a[2]),
        .WR_CNT(cnt_a[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] get_en(input int id);
        case (id)
            0:       return en0;
            1:       return en1;
            default: return {2'b00, en2};
        endcase
    endfunction

    // Behavioural latch array: an entry follows LAT_D while its enable is high.
    always @(negedge CLK) begin : latch_model
        logic [7:0] e;
        for (int id = 0; id < 3; id++) begin
            e = get_en(id);
            for (int i = 0; i < 8; i++) begin
                if (e[i]) mem[id][i] = d_o[id];
            end
        end
    end

    task automatic apply_reset();
        RSTB = 1'b0;
        for (int id = 0; id < 3; id++) begin
            v_a[id] = 1'b0; a_a[id] = '0; d_a[id] = '0;
        end
        repeat (3) @(posedge CLK);
        #2 RSTB = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Waits for WR_READY, issues one request, then records nsamp post-edge samples
    // (sample 0 is taken just after the accepting edge).
    task automatic drive_write(input int id, input logic [2:0] a, input logic [7:0] dd,
                               input int nsamp, output bit ok);
        int guard = 0;
        ok = 1'b1;
        v_a[id] = 1'b1; a_a[id] = a; d_a[id] = dd;
        while (!rdy_a[id] && guard < 50) begin
            @(posedge CLK); #1; guard++;
        end
        if (!rdy_a[id]) begin
            ok = 1'b0;
            v_a[id] = 1'b0;
            return;
        end
        for (int j = 0; j < nsamp; j++) begin
            @(posedge CLK); #1;
            if (j == 0) v_a[id] = 1'b0;
            tr_en[j]   = get_en(id);
            tr_d[j]    = d_o[id];
            tr_cnt[j]  = cnt_a[id];
            tr_rdy[j]  = rdy_a[id];
            tr_busy[j] = busy_a[id];
            tr_err[j]  = err_a[id];
        end
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        for (int id = 0; id < 3; id++) begin
            v_a[id] = 1'b0; a_a[id] = '0; d_a[id] = '0;
        end
        repeat (3) @(posedge CLK); #1;
        for (int id = 0; id < 3; id++) begin
            tests++;
            if (rdy_a[id] !== 1'b1 || get_en(id) !== 8'h00 || d_o[id] !== 8'h00 ||
                cnt_a[id] !== 8'h00 || busy_a[id] !== 1'b0 || err_a[id] !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold dut%0d: rdy=%b en=%h d=%h cnt=%h busy=%b err=%b, want 1/00/00/00/0/0",
                         id, rdy_a[id], get_en(id), d_o[id], cnt_a[id], busy_a[id], err_a[id]);
            end
        end
        #2 RSTB = 1'b1;
        @(posedge CLK); #1;
        for (int id = 0; id < 3; id++) begin
            tests++;
            if (rdy_a[id] !== 1'b1 || get_en(id) !== 8'h00 || d_o[id] !== 8'h00 || cnt_a[id] !== 8'h00) begin
                fails++;
                $display("FAIL reset_release dut%0d: rdy=%b en=%h d=%h cnt=%h, want 1/00/00/00",
                         id, rdy_a[id], get_en(id), d_o[id], cnt_a[id]);
            end
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [7:0] exp_en;
        drive_write(0, 3'd3, 8'hA5, 5, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_accept: timeout waiting for WR_READY"); return; end
        for (int j = 0; j < 5; j++) begin
            exp_en = (j == 1) ? 8'h08 : 8'h00;
            tests++;
            if (tr_en[j] !== exp_en || tr_d[j] !== 8'hA5 || tr_rdy[j] !== (j >= 3) || tr_busy[j] !== (j < 3)) begin
                fails++;
                $display("FAIL basic_cycle%0d: en=%h d=%h rdy=%b busy=%b, want %h/a5/%b/%b",
                         j + 1, tr_en[j], tr_d[j], tr_rdy[j], tr_busy[j], exp_en, j >= 3, j < 3);
            end
        end
        tests++;
        if (tr_cnt[2] !== 8'd0 || tr_cnt[3] !== 8'd1 || mem[0][3] !== 8'hA5) begin
            fails++;
            $display("FAIL basic_count: cnt=%0d->%0d mem=%h, want 0->1 a5", tr_cnt[2], tr_cnt[3], mem[0][3]);
        end
    endtask

    task automatic test_stretched();
        bit ok;
        logic [7:0] exp_en;
        drive_write(1, 3'd7, 8'h3C, 9, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL stretch_accept: timeout waiting for WR_READY"); return; end
        for (int j = 0; j < 9; j++) begin
            exp_en = (j >= 2 && j < 5) ? 8'h80 : 8'h00;
            tests++;
            if (tr_en[j] !== exp_en || tr_d[j] !== 8'h3C || tr_rdy[j] !== (j >= 7)) begin
                fails++;
                $display("FAIL stretch_offset%0d: en=%h d=%h rdy=%b, want %h/3c/%b",
                         j, tr_en[j], tr_d[j], tr_rdy[j], exp_en, j >= 7);
            end
        end
        tests++;
        if (tr_cnt[7] !== 8'd1 || mem[1][7] !== 8'h3C) begin
            fails++;
            $display("FAIL stretch_count: cnt=%0d mem=%h, want 1 3c", tr_cnt[7], mem[1][7]);
        end
    endtask

    task automatic test_illegal_addr();
        bit ok;
        drive_write(2, 3'd1, 8'h5A, 4, ok);
        tests++;
        if (!ok || tr_cnt[3] !== 8'd1) begin
            fails++; $display("FAIL illegal_setup: ok=%b cnt=%0d, want 1 1", ok, tr_cnt[3]);
        end
        for (int k = 6; k < 8; k++) begin
            drive_write(2, 3'(k), 8'hFF, 4, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL illegal_accept%0d: timeout", k); continue; end
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (tr_err[j] !== (j == 0) || tr_en[j] !== 8'h00 || tr_d[j] !== 8'h5A ||
                    tr_cnt[j] !== 8'd1 || tr_rdy[j] !== 1'b1) begin
                    fails++;
                    $display("FAIL illegal_addr%0d_offset%0d: err=%b en=%h d=%h cnt=%0d rdy=%b, want %b/00/5a/1/1",
                             k, j, tr_err[j], tr_en[j], tr_d[j], tr_cnt[j], tr_rdy[j], j == 0);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [2:0] a;
        logic [7:0] dd, exp_en, exp_d, last_d;
        logic [7:0] ref_mem [8];
        bit written [8];
        bit legal, exp_rdy;
        int n, exp_cnt;
        for (int id = 1; id < 3; id++) begin
            apply_reset();
            last_d = 8'h00;
            exp_cnt = 0;
            for (int i = 0; i < 8; i++) written[i] = 1'b0;
            n = S_P[id] + P_P[id] + H_P[id];
            for (int t = 0; t < 14; t++) begin
                a  = 3'($urandom_range(0, 7));
                dd = 8'($urandom);
                legal = (int'(a) < D_P[id]);
                drive_write(id, a, dd, n + 1, ok);
                tests++;
                if (!ok) begin fails++; $display("FAIL rand_accept dut%0d: timeout", id); continue; end
                if (legal) begin
                    exp_cnt++;
                    last_d = dd;
                    ref_mem[a] = dd;
                    written[a] = 1'b1;
                end
                exp_d = last_d;
                for (int j = 0; j <= n; j++) begin
                    exp_en  = (legal && j >= S_P[id] && j < S_P[id] + P_P[id]) ? (8'd1 << a) : 8'd0;
                    exp_rdy = legal ? (j >= n) : 1'b1;
                    tests++;
                    if (tr_en[j] !== exp_en || tr_d[j] !== exp_d || tr_rdy[j] !== exp_rdy ||
                        tr_busy[j] !== !exp_rdy || tr_err[j] !== (!legal && j == 0)) begin
                        fails++;
                        $display("FAIL rand dut%0d a=%0d off%0d: en=%h d=%h rdy=%b busy=%b err=%b, want %h/%h/%b/%b/%b",
                                 id, a, j, tr_en[j], tr_d[j], tr_rdy[j], tr_busy[j], tr_err[j],
                                 exp_en, exp_d, exp_rdy, !exp_rdy, !legal && j == 0);
                    end
                end
                tests++;
                if (tr_cnt[n] !== 8'(exp_cnt)) begin
                    fails++; $display("FAIL rand_cnt dut%0d: cnt=%0d, want %0d", id, tr_cnt[n], exp_cnt);
                end
                repeat ($urandom_range(0, 3)) @(posedge CLK);
                #1;
            end
            for (int i = 0; i < 8; i++) begin
                if (written[i]) begin
                    tests++;
                    if (mem[id][i] !== ref_mem[i]) begin
                        fails++;
                        $display("FAIL rand_mem dut%0d[%0d]: got %h, want %h", id, i, mem[id][i], ref_mem[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int cyc = 0;
        logic rdy_before, busy_before;
        logic [7:0] d_before;
        logic [7:0] ref_mem [8];
        apply_reset();
        v_a[0] = 1'b1; a_a[0] = 3'd0; d_a[0] = 8'd0;
        while (k < 10 && cyc < 200) begin
            rdy_before  = rdy_a[0];
            busy_before = busy_a[0];
            d_before    = d_o[0];
            @(posedge CLK); #1;
            cyc++;
            tests++;
            if ($countones(en0) > 1 || (busy_before && d_o[0] !== d_before) || busy_before === rdy_before) begin
                fails++;
                $display("FAIL b2b_cycle%0d: en=%h d=%h->%h busy=%b rdy=%b, want one-hot, D held while busy",
                         cyc, en0, d_before, d_o[0], busy_before, rdy_before);
            end
            if (rdy_before) begin
                ref_mem[k % 8] = 8'(k * 17);
                k++;
                if (k < 10) begin
                    a_a[0] = 3'(k % 8);
                    d_a[0] = 8'(k * 17);
                end else begin
                    v_a[0] = 1'b0;
                end
            end
        end
        tests++;
        if (k !== 10 || cyc !== 37) begin
            fails++; $display("FAIL b2b_accepts: %0d accepts in %0d cycles, want 10 in 37", k, cyc);
        end
        repeat (4) @(posedge CLK);
        #1;
        tests++;
        if (cnt_a[0] !== 8'd10) begin
            fails++; $display("FAIL b2b_count: cnt=%0d, want 10", cnt_a[0]);
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (mem[0][i] !== ref_mem[i]) begin
                fails++; $display("FAIL b2b_mem[%0d]: got %h, want %h", i, mem[0][i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_open();
        bit ok;
        int guard = 0;
        v_a[0] = 1'b1; a_a[0] = 3'd2; d_a[0] = 8'h77;
        while (!rdy_a[0] && guard < 20) begin @(posedge CLK); #1; guard++; end
        @(posedge CLK); #1;
        v_a[0] = 1'b0;
        guard = 0;
        while (en0[2] !== 1'b1 && guard < 20) begin @(posedge CLK); #1; guard++; end
        tests++;
        if (en0 !== 8'h04) begin
            fails++; $display("FAIL midrst_open: en=%h, want 04", en0);
        end
        #2 RSTB = 1'b0;
        #1;
        tests++;
        if (en0 !== 8'h00 || cnt_a[0] !== 8'd0 || rdy_a[0] !== 1'b1 || d_o[0] !== 8'h00) begin
            fails++;
            $display("FAIL midrst_async: en=%h cnt=%0d rdy=%b d=%h, want 00/0/1/00", en0, cnt_a[0], rdy_a[0], d_o[0]);
        end
        @(negedge CLK);
        RSTB = 1'b1;
        drive_write(0, 3'd5, 8'hC3, 5, ok);
        tests++;
        if (!ok || tr_en[0] !== 8'h00 || tr_en[1] !== 8'h20 || tr_en[2] !== 8'h00 ||
            tr_d[1] !== 8'hC3 || tr_cnt[3] !== 8'd1 || mem[0][5] !== 8'hC3) begin
            fails++;
            $display("FAIL midrst_resume: ok=%b en=%h,%h,%h d=%h cnt=%0d mem=%h, want 1 00,20,00 c3 1 c3",
                     ok, tr_en[0], tr_en[1], tr_en[2], tr_d[1], tr_cnt[3], mem[0][5]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stretched();
        test_illegal_addr();
        test_random();
        test_back_to_back();
        test_reset_mid_open();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
